// File: rtl/axi_aw_buffer.sv
// AXI write-address skid FIFO with burst legality checking.
// Flags 4KB crossings and malformed bursts; optionally drops illegal bursts.
module axi_aw_buffer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 4,
    parameter bit DROP_ILLEGAL = 1'b0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ID_WIDTH-1:0]         s_awid,
    input  logic [ADDR_WIDTH-1:0]       s_awaddr,
    input  logic [7:0]                  s_awlen,
    input  logic [2:0]                  s_awsize,
    input  logic [1:0]                  s_awburst,
    input  logic                        s_awlock,
    input  logic [3:0]                  s_awcache,
    input  logic [2:0]                  s_awprot,
    input  logic [3:0]                  s_awqos,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    output logic [ID_WIDTH-1:0]         m_awid,
    output logic [ADDR_WIDTH-1:0]       m_awaddr,
    output logic [7:0]                  m_awlen,
    output logic [2:0]                  m_awsize,
    output logic [1:0]                  m_awburst,
    output logic                        m_awlock,
    output logic [3:0]                  m_awcache,
    output logic [2:0]                  m_awprot,
    output logic [3:0]                  m_awqos,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        err_4k,
    output logic                        err_burst,
    output logic [7:0]                  err_count
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int PW       = ID_WIDTH + ADDR_WIDTH + 25;
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] BURST_RSVD = 2'b11;

    logic [PW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_nxt;

    logic             accept;
    logic             push;
    logic             pop;
    logic             is_4k;
    logic             is_burst;
    logic             illegal;
    logic             wrap_len_ok;
    logic             misaligned;
    logic             oversize;
    logic [16:0]      burst_bytes;
    logic [16:0]      end_off;
    logic [6:0]       align_mask;
    logic [PW-1:0]    s_payload;

    // Handshake: a beat moves on a rising edge where valid && ready; valid never
    // waits on ready, ready is registered, and payload is held while valid && !ready.
    assign accept = s_awvalid && s_awready;
    assign pop    = (level_q != '0) && m_awready;
    assign push   = accept && !(DROP_ILLEGAL && illegal);

    assign s_payload = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
                        s_awlock, s_awcache, s_awprot, s_awqos};

    always_comb begin
        burst_bytes = (17'(s_awlen) + 17'd1) << s_awsize;
        end_off     = 17'(s_awaddr[11:0]) + burst_bytes;
        is_4k       = (s_awburst == BURST_INCR) && (end_off > 17'd4096);

        align_mask  = 7'((8'd1 << s_awsize) - 8'd1);
        misaligned  = |(s_awaddr[6:0] & align_mask);
        wrap_len_ok = (s_awlen == 8'd1) || (s_awlen == 8'd3) ||
                      (s_awlen == 8'd7) || (s_awlen == 8'd15);
        oversize    = (s_awsize > 3'(MAX_SIZE));

        is_burst    = (s_awburst == BURST_RSVD) ||
                      ((s_awburst == BURST_WRAP) && (!wrap_len_ok || misaligned)) ||
                      oversize;
        illegal     = is_4k || is_burst;
    end

    always_comb begin
        level_nxt = level_q;
        case ({push, pop})
            2'b10:   level_nxt = level_q + 1'b1;
            2'b01:   level_nxt = level_q - 1'b1;
            default: level_nxt = level_q;
        endcase
    end

    // Storage is cleared on reset so the head payload reads as zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr      <= '0;
            rptr      <= '0;
            level_q   <= '0;
            s_awready <= 1'b0;
            err_4k    <= 1'b0;
            err_burst <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (push) begin
                mem[wptr] <= s_payload;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            level_q   <= level_nxt;
            s_awready <= (level_nxt < LVL_W'(DEPTH));
            err_4k    <= accept && is_4k;
            err_burst <= accept && is_burst;
            if (accept && illegal && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
            m_awlock, m_awcache, m_awprot, m_awqos} = mem[rptr];
    assign m_awvalid = (level_q != '0);
    assign level     = level_q;

endmodule

// File: tb/tb_axi_aw_buffer.sv
// Directed bench for axi_aw_buffer: one forwarding instance (scoreboarded)
// and one drop-illegal instance, sharing clock, reset and payload fields.
module tb_axi_aw_buffer;

    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] WRAP = 2'b10;
    localparam logic [1:0] RSVD = 2'b11;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;

    logic        valid0, mready0, valid1, mready1;

    logic        s_awready0, m_awvalid0, m_awlock0, err_4k0, err_burst0;
    logic [3:0]  m_awid0, m_awcache0, m_awqos0;
    logic [31:0] m_awaddr0;
    logic [7:0]  m_awlen0, err_count0;
    logic [2:0]  m_awsize0, m_awprot0, level0;
    logic [1:0]  m_awburst0;

    logic        s_awready1, m_awvalid1, m_awlock1, err_4k1, err_burst1;
    logic [3:0]  m_awid1, m_awcache1, m_awqos1;
    logic [31:0] m_awaddr1;
    logic [7:0]  m_awlen1, err_count1;
    logic [2:0]  m_awsize1, m_awprot1, level1;
    logic [1:0]  m_awburst1;

    int          total = 0;
    int          bad = 0;
    logic [35:0] exp_q[$];

    always #5 aclk = ~aclk;

    axi_aw_buffer #(.ADDR_WIDTH(32), .ID_WIDTH(4), .DATA_WIDTH(64), .DEPTH(4), .DROP_ILLEGAL(1'b0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_awid(awid), .s_awaddr(awaddr), .s_awlen(awlen), .s_awsize(awsize), .s_awburst(awburst),
        .s_awlock(awlock), .s_awcache(awcache), .s_awprot(awprot), .s_awqos(awqos),
        .s_awvalid(valid0), .s_awready(s_awready0),
        .m_awid(m_awid0), .m_awaddr(m_awaddr0), .m_awlen(m_awlen0), .m_awsize(m_awsize0),
        .m_awburst(m_awburst0), .m_awlock(m_awlock0), .m_awcache(m_awcache0), .m_awprot(m_awprot0),
        .m_awqos(m_awqos0), .m_awvalid(m_awvalid0), .m_awready(mready0),
        .level(level0), .err_4k(err_4k0), .err_burst(err_burst0), .err_count(err_count0)
    );

    axi_aw_buffer #(.ADDR_WIDTH(32), .ID_WIDTH(4), .DATA_WIDTH(64), .DEPTH(4), .DROP_ILLEGAL(1'b1)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_awid(awid), .s_awaddr(awaddr), .s_awlen(awlen), .s_awsize(awsize), .s_awburst(awburst),
        .s_awlock(awlock), .s_awcache(awcache), .s_awprot(awprot), .s_awqos(awqos),
        .s_awvalid(valid1), .s_awready(s_awready1),
        .m_awid(m_awid1), .m_awaddr(m_awaddr1), .m_awlen(m_awlen1), .m_awsize(m_awsize1),
        .m_awburst(m_awburst1), .m_awlock(m_awlock1), .m_awcache(m_awcache1), .m_awprot(m_awprot1),
        .m_awqos(m_awqos1), .m_awvalid(m_awvalid1), .m_awready(mready1),
        .level(level1), .err_4k(err_4k1), .err_burst(err_burst1), .err_count(err_count1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bt);
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt;
    endtask

    // One cycle on dut0: scoreboard any pop, record any push, then cross the edge.
    task automatic tick0(output bit acc);
        bit p, q;
        p = m_awvalid0 && mready0;
        q = valid0 && s_awready0;
        if (p) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_pop observed=%0h expected=none", {m_awid0, m_awaddr0});
            end else begin
                chk("order", 64'({m_awid0, m_awaddr0}), 64'(exp_q.pop_front()));
            end
        end
        if (q) exp_q.push_back({awid, awaddr});
        @(posedge aclk);
        #1;
        acc = q;
    endtask

    task automatic beat0(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        set_beat(id, a, len, sz, bt);
        valid0 = 1'b1;
        while (!acc && n < 20) begin
            tick0(acc);
            n++;
        end
        valid0 = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $error("FAIL beat0_timeout observed=no_accept expected=accept addr=%0h", a);
        end
    endtask

    task automatic beat1(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
        int n;
        n = 0;
        set_beat(id, a, len, sz, bt);
        valid1 = 1'b1;
        while (!s_awready1 && n < 20) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (!s_awready1) begin
            total++;
            bad++;
            $error("FAIL beat1_timeout observed=no_ready expected=ready addr=%0h", a);
        end
        @(posedge aclk);
        #1;
        valid1 = 1'b0;
    endtask

    task automatic drain0();
        bit acc;
        int n;
        n = 0;
        while (level0 != 3'd0 && n < 12) begin
            tick0(acc);
            n++;
        end
        chk("drain_level", 64'(level0), 64'(0));
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        bit acc;
        valid0 = 1'b0; valid1 = 1'b0; mready0 = 1'b0; mready1 = 1'b0;
        set_beat(4'd0, 32'd0, 8'd0, 3'd0, INCR);
        awlock = 1'b0; awcache = 4'd0; awprot = 3'd0; awqos = 4'd0;

        // Reset state, before any clock edge
        #3;
        chk("rst_ready", 64'(s_awready0), 64'(0));
        chk("rst_mvalid", 64'(m_awvalid0), 64'(0));
        chk("rst_level", 64'(level0), 64'(0));
        chk("rst_errcnt", 64'(err_count0), 64'(0));
        chk("rst_err4k", 64'(err_4k0), 64'(0));
        chk("rst_maddr", 64'(m_awaddr0), 64'(0));
        #20;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("ready_after_release", 64'(s_awready0), 64'(1));

        // Fill to full with downstream stalled
        awlock = 1'b1; awcache = 4'hA; awprot = 3'd5; awqos = 4'hC;
        beat0(4'd1, 32'h1000, 8'd3, 3'd3, INCR);
        chk("first_mvalid", 64'(m_awvalid0), 64'(1));
        chk("first_level", 64'(level0), 64'(1));
        awlock = 1'b0; awcache = 4'h3; awprot = 3'd2; awqos = 4'h1;
        beat0(4'd2, 32'h1040, 8'd3, 3'd3, INCR);
        beat0(4'd3, 32'h1080, 8'd3, 3'd3, INCR);
        beat0(4'd4, 32'h10C0, 8'd3, 3'd3, INCR);
        chk("full_level", 64'(level0), 64'(4));
        chk("full_ready", 64'(s_awready0), 64'(0));
        chk("head_addr", 64'(m_awaddr0), 64'(32'h1000));
        chk("head_id", 64'(m_awid0), 64'(1));
        chk("head_lock", 64'(m_awlock0), 64'(1));
        chk("head_cache", 64'(m_awcache0), 64'(4'hA));
        chk("head_prot", 64'(m_awprot0), 64'(5));
        chk("head_qos", 64'(m_awqos0), 64'(4'hC));
        tick0(acc);
        chk("stall_hold_addr", 64'(m_awaddr0), 64'(32'h1000));
        chk("stall_hold_len", 64'(m_awlen0), 64'(3));

        // Stream through the full FIFO: pointers wrap, order preserved
        mready0 = 1'b1;
        beat0(4'd5, 32'h2000, 8'd3, 3'd3, INCR);
        chk("stream_level_a", 64'(level0), 64'(3));
        beat0(4'd6, 32'h2040, 8'd3, 3'd3, INCR);
        beat0(4'd7, 32'h2080, 8'd3, 3'd3, INCR);
        beat0(4'd8, 32'h20C0, 8'd3, 3'd3, INCR);
        chk("stream_level_b", 64'(level0), 64'(3));
        drain0();

        // 4KB crossing: 0xFF0 + 32 bytes, forwarded anyway
        beat0(4'd9, 32'h0FF0, 8'd3, 3'd3, INCR);
        chk("x4k_err4k", 64'(err_4k0), 64'(1));
        chk("x4k_errburst", 64'(err_burst0), 64'(0));
        chk("x4k_errcnt", 64'(err_count0), 64'(1));
        chk("x4k_forward", 64'(m_awaddr0), 64'(32'h0FF0));
        tick0(acc);
        chk("x4k_pulse_end", 64'(err_4k0), 64'(0));
        // Ends exactly at 0x1000: legal
        beat0(4'hA, 32'h0FE0, 8'd3, 3'd3, INCR);
        chk("edge4k_err4k", 64'(err_4k0), 64'(0));
        chk("edge4k_errcnt", 64'(err_count0), 64'(1));
        drain0();

        // Drop-illegal instance
        beat1(4'd1, 32'h100, 8'd2, 3'd3, WRAP);
        chk("d1_wraplen_errb", 64'(err_burst1), 64'(1));
        chk("d1_wraplen_err4k", 64'(err_4k1), 64'(0));
        chk("d1_wraplen_level", 64'(level1), 64'(0));
        chk("d1_wraplen_mvalid", 64'(m_awvalid1), 64'(0));
        chk("d1_wraplen_cnt", 64'(err_count1), 64'(1));
        chk("d1_wraplen_ready", 64'(s_awready1), 64'(1));
        beat1(4'd2, 32'h100, 8'd3, 3'd3, WRAP);
        chk("d1_legal_errb", 64'(err_burst1), 64'(0));
        chk("d1_legal_level", 64'(level1), 64'(1));
        chk("d1_legal_id", 64'(m_awid1), 64'(2));
        beat1(4'd3, 32'h104, 8'd3, 3'd3, WRAP);
        chk("d1_misalign_errb", 64'(err_burst1), 64'(1));
        chk("d1_misalign_level", 64'(level1), 64'(1));
        beat1(4'd4, 32'h0, 8'd0, 3'd4, INCR);
        chk("d1_oversize_errb", 64'(err_burst1), 64'(1));
        chk("d1_oversize_err4k", 64'(err_4k1), 64'(0));
        beat1(4'd5, 32'h0, 8'd0, 3'd0, RSVD);
        chk("d1_rsvd_errb", 64'(err_burst1), 64'(1));
        chk("d1_rsvd_cnt", 64'(err_count1), 64'(4));
        beat1(4'd6, 32'hFF8, 8'd0, 3'd4, INCR);
        chk("d1_both_err4k", 64'(err_4k1), 64'(1));
        chk("d1_both_errb", 64'(err_burst1), 64'(1));
        chk("d1_both_cnt", 64'(err_count1), 64'(5));
        chk("d1_head_addr", 64'(m_awaddr1), 64'(32'h100));

        // Saturation: 300 more illegal bursts, one per cycle
        set_beat(4'd7, 32'h0, 8'd0, 3'd0, RSVD);
        valid1 = 1'b1;
        repeat (250) @(posedge aclk);
        #1;
        chk("sat_cnt_250", 64'(err_count1), 64'(255));
        repeat (50) @(posedge aclk);
        #1;
        valid1 = 1'b0;
        chk("sat_cnt_300", 64'(err_count1), 64'(255));
        chk("sat_level", 64'(level1), 64'(1));

        // Mid-operation asynchronous reset with three entries held
        mready0 = 1'b0;
        beat0(4'd1, 32'h3000, 8'd1, 3'd2, INCR);
        beat0(4'd2, 32'h3040, 8'd1, 3'd2, INCR);
        beat0(4'd3, 32'h3080, 8'd1, 3'd2, INCR);
        chk("pre_rst_level", 64'(level0), 64'(3));
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_mvalid", 64'(m_awvalid0), 64'(0));
        chk("arst_level", 64'(level0), 64'(0));
        chk("arst_ready", 64'(s_awready0), 64'(0));
        chk("arst_maddr", 64'(m_awaddr0), 64'(0));
        chk("arst_errcnt0", 64'(err_count0), 64'(0));
        chk("arst_errcnt1", 64'(err_count1), 64'(0));
        chk("arst_level1", 64'(level1), 64'(0));
        #3;
        aresetn = 1'b1;
        exp_q.delete();
        @(posedge aclk);
        #1;
        chk("rel_ready", 64'(s_awready0), 64'(1));
        chk("rel_mvalid", 64'(m_awvalid0), 64'(0));
        mready0 = 1'b1;
        beat0(4'hB, 32'h4000, 8'd0, 3'd3, INCR);
        drain0();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
